// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide, combinational-read, posedge-write data memory.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module load_store_unit #(
    parameter int ADDR_W     = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_done,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [31:0]       mem_WD,
    input  logic [31:0]       mem_RD
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t            state, state_nxt;
    logic              err_q, signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, merge_q, rdata_q;
    logic [4:0]        shift;
    logic [31:0]       mask, merged;

    function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == 2'b01 && off[0]) ||
               (size == 2'b10 && off != 2'b00);
    endfunction

    // Bit position of the addressed lane's least significant bit inside the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return BIG_ENDIAN ? 5'd24 - {off, 3'b000} : {off, 3'b000};
            2'b01:   return BIG_ENDIAN ? 5'd16 - {off[1], 4'b0000} : {off[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                           input logic [31:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        case (size)
            2'b00:   return sgn ? 32'(b) : {24'd0, raw[7:0]};
            2'b01:   return sgn ? 32'(h) : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid)
                err_q <= is_err(req_size, req_addr[1:0]);
            if (state == LOAD)
                rdata_q <= extend(size_q, signed_q, mem_RD >> shift);
            if (state == RMW_RD)
                merge_q <= mem_RD;
        end
    end

    // Request fields are pure data; they are only consumed after a capture.
    always_ff @(posedge CLK) begin
        if (state == IDLE && req_valid) begin
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_err(req_size, req_addr[1:0])) state_nxt = RESP;
                    else if (!req_we)                    state_nxt = LOAD;
                    else if (req_size == 2'b10)          state_nxt = WRITE;
                    else                                 state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign shift  = lane_shift(size_q, addr_q[1:0]);
    assign mask   = lane_mask(size_q) << shift;
    assign merged = (merge_q & ~mask) | ((wdata_q << shift) & mask);

    assign req_ready  = (state == IDLE);
    assign resp_done  = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_A      = (state == LOAD || state == RMW_RD || state == WRITE) ?
                        addr_q[ADDR_W+1:2] : '0;
    // A reset arriving in WRITE must suppress the store in that same cycle.
    assign mem_WE     = (state == WRITE) && !RESET;
    assign mem_WD     = (state != WRITE) ? 32'd0 :
                        (size_q == 2'b10) ? wdata_q : merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences,
// and random requests checked against a byte-addressed memory model.
module tb_load_store_unit;
    localparam int ADDR_W = 6;
    localparam bit BE     = 1'b1;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_done, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_A;
    logic              mem_WE;
    logic [31:0]       mem_WD, mem_RD;

    load_store_unit #(.ADDR_W(ADDR_W), .BIG_ENDIAN(BE)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_done(resp_done),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_A(mem_A),
        .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    always #5 CLK = ~CLK;

    // Data memory
    logic [31:0] dmem     [64];
    logic [31:0] init_mem [64];
    logic        load_mem;
    int          we_cnt = 0;
    int          done_cnt = 0;
    assign mem_RD = dmem[mem_A];
    always @(posedge CLK) begin
        if (load_mem) dmem <= init_mem;
        else if (mem_WE) begin
            dmem[mem_A] <= mem_WD;
            we_cnt <= we_cnt + 1;
        end
        if (resp_done) done_cnt <= done_cnt + 1;
    end

    // Reference model: plain byte array, endianness applied at the word boundary
    logic [7:0]  rb [256];
    logic [31:0] last_rd;
    int checks = 0;
    int errors = 0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [7:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic int ref_lat(input logic we, input logic [1:0] sz, input logic [7:0] a);
        if (ref_err(sz, a)) return 1;
        if (!we || sz == 2'b10) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [7:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (BE) v = {v[23:0], rb[int'(a) + i]};
            else    v = v | (32'(rb[int'(a) + i]) << (8 * i));
        end
        if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        int n;
        n = nbytes(sz);
        for (int i = 0; i < n; i++)
            rb[int'(a) + i] = BE ? wd[8 * (n - 1 - i) +: 8] : wd[8 * i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            if (BE) r[31 - 8 * k -: 8] = rb[4 * w + k];
            else    r[8 * k +: 8]      = rb[4 * w + k];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_mem(input string nm);
        int bad;
        bad = 0;
        for (int w = 0; w < 64; w++) if (dmem[w] !== ref_word(w)) bad++;
        chk(nm, 32'(bad), 32'd0);
    endtask

    // Counts edges from the accept edge until resp_done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!resp_done && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [7:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int wes);
        int w0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        w0 = we_cnt;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        wait_done(lat);
        err = resp_err;
        rd  = resp_rdata;
        wes = we_cnt - w0;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl [19];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, wes, w0, d0;
        logic err;
        logic [31:0] rd, exp_rd, x;

        tbl[0]  = '{1'b0, 2'b00, 1'b1, 8'h0D, 32'h0,        32'h0000_0022, 1'b0, 2};
        tbl[1]  = '{1'b0, 2'b01, 1'b0, 8'h0E, 32'h0,        32'h0000_3344, 1'b0, 2};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 8'h0F, 32'h0,        32'h0000_0044, 1'b0, 2};
        tbl[3]  = '{1'b1, 2'b10, 1'b0, 8'h0C, 32'h8000_1234, 32'h0,        1'b0, 2};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 8'h0C, 32'h0,        32'hFFFF_FF80, 1'b0, 2};
        tbl[5]  = '{1'b0, 2'b01, 1'b1, 8'h0C, 32'h0,        32'hFFFF_8000, 1'b0, 2};
        tbl[6]  = '{1'b0, 2'b01, 1'b1, 8'h0E, 32'h0,        32'h0000_1234, 1'b0, 2};
        tbl[7]  = '{1'b0, 2'b00, 1'b0, 8'h0C, 32'h0,        32'h0000_0080, 1'b0, 2};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 8'h09, 32'h0000_00AB, 32'h0,        1'b0, 3};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 8'h08, 32'h0,        32'h11AB_3344, 1'b0, 2};
        tbl[10] = '{1'b1, 2'b01, 1'b0, 8'h0A, 32'h0000_CAFE, 32'h0,        1'b0, 3};
        tbl[11] = '{1'b0, 2'b10, 1'b0, 8'h08, 32'h0,        32'h11AB_CAFE, 1'b0, 2};
        tbl[12] = '{1'b1, 2'b10, 1'b0, 8'h08, 32'hDEAD_BEEF, 32'h0,        1'b0, 2};
        tbl[13] = '{1'b0, 2'b10, 1'b0, 8'h06, 32'h0,        32'h0,        1'b1, 1};
        tbl[14] = '{1'b1, 2'b01, 1'b0, 8'h03, 32'h0000_1234, 32'h0,        1'b1, 1};
        tbl[15] = '{1'b0, 2'b11, 1'b0, 8'h10, 32'h0,        32'h0,        1'b1, 1};
        tbl[16] = '{1'b0, 2'b10, 1'b0, 8'h08, 32'h0,        32'hDEAD_BEEF, 1'b0, 2};
        tbl[17] = '{1'b0, 2'b00, 1'b1, 8'h0B, 32'h0,        32'hFFFF_FFEF, 1'b0, 2};
        tbl[18] = '{1'b0, 2'b00, 1'b0, 8'h0E, 32'h0,        32'h0000_0012, 1'b0, 2};

        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[2] = 32'h1122_3344;
        init_mem[3] = 32'h1122_3344;
        for (int w = 0; w < 64; w++)
            for (int k = 0; k < 4; k++)
                rb[4 * w + k] = BE ? init_mem[w][31 - 8 * k -: 8] : init_mem[w][8 * k +: 8];

        RESET = 1'b1; load_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chkb("rst_ready", req_ready, 1'b1);
        chkb("rst_done", resp_done, 1'b0);
        chkb("rst_err", resp_err, 1'b0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chkb("rst_we", mem_WE, 1'b0);
        chk("rst_A", 32'(mem_A), 32'd0);
        chk("rst_WD", mem_WD, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; load_mem = 1'b0;
        last_rd = 32'd0;
        @(posedge CLK); #1;

        // Directed vectors
        for (int i = 0; i < 19; i++) begin
            do_req(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, err, rd, wes);
            exp_rd = (tbl[i].we || tbl[i].err) ? last_rd : tbl[i].rd;
            if (!tbl[i].we && !tbl[i].err) last_rd = tbl[i].rd;
            if (tbl[i].we && !tbl[i].err) ref_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chkb($sformatf("vec%0d_err", i), err, tbl[i].err);
            chk($sformatf("vec%0d_rdata", i), rd, exp_rd);
            chk($sformatf("vec%0d_writes", i), 32'(wes),
                (tbl[i].we && !tbl[i].err) ? 32'd1 : 32'd0);
            chk_mem($sformatf("vec%0d_mem", i));
        end

        // Reset arriving while a half-word store is in its WRITE cycle
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 8'h0A; req_wdata = 32'h0000_5555;
        w0 = we_cnt; d0 = done_cnt;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        chkb("rstwr_we_in_write", mem_WE, 1'b1);
        RESET = 1'b1;
        #1;
        chkb("rstwr_we_masked", mem_WE, 1'b0);
        @(posedge CLK); #1;
        chkb("rstwr_ready", req_ready, 1'b1);
        chkb("rstwr_done", resp_done, 1'b0);
        chkb("rstwr_err", resp_err, 1'b0);
        chk("rstwr_rdata", resp_rdata, 32'd0);
        chk("rstwr_A", 32'(mem_A), 32'd0);
        chk("rstwr_WD", mem_WD, 32'd0);
        chk("rstwr_writes", 32'(we_cnt - w0), 32'd0);
        chk_mem("rstwr_mem");
        @(negedge CLK);
        RESET = 1'b0;
        last_rd = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rstwr_no_done", 32'(done_cnt - d0), 32'd0);

        // Back-to-back SW then LW to the same word with req_valid held high
        x = $urandom;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 8'h40; req_wdata = x;
        w0 = we_cnt; d0 = done_cnt;
        @(posedge CLK); #1;
        req_we = 1'b0; req_wdata = 32'd0;
        wait_done(lat);
        chk("b2b_sw_lat", 32'(lat), 32'd2);
        @(posedge CLK); #1;
        chkb("b2b_idle_ready", req_ready, 1'b1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        wait_done(lat);
        chk("b2b_lw_lat", 32'(lat), 32'd2);
        chkb("b2b_lw_err", resp_err, 1'b0);
        chk("b2b_lw_rdata", resp_rdata, x);
        @(posedge CLK); #1;
        repeat (2) @(posedge CLK);
        #1;
        chk("b2b_writes", 32'(we_cnt - w0), 32'd1);
        chk("b2b_dones", 32'(done_cnt - d0), 32'd2);
        ref_store(2'b10, 8'h40, x);
        last_rd = x;
        chk_mem("b2b_mem");

        // Random requests against the byte-level model
        for (int i = 0; i < 150; i++) begin
            logic        we, sg, e;
            logic [1:0]  sz;
            logic [7:0]  a;
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            e = ref_err(sz, a);
            exp_rd = (!we && !e) ? ref_load(sz, sg, a) : last_rd;
            do_req(we, sz, sg, a, wd, lat, err, rd, wes);
            if (we && !e) ref_store(sz, a, wd);
            last_rd = exp_rd;
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(we, sz, a)));
            chkb($sformatf("rnd%0d_err", i), err, e);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_writes", i), 32'(wes), (we && !e) ? 32'd1 : 32'd0);
            chk_mem($sformatf("rnd%0d_mem", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
